// File: rtl/reg_file_param.sv
// Parameterised two-read/one-write register file on the falling clock edge,
// with write-through bypass and a self-timed clear sweep across all registers.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | normal operation: writes, reads and bypass active
// SWEEP | clearing register PTR each edge; writes/CLR ignored, Q0/Q1 held at 0
module reg_file_param #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              CLKb,
  input  logic              RSTb,
  input  logic [DATA_W-1:0] D,
  input  logic              ENW,
  input  logic [ADDR_W-1:0] WRA,
  input  logic              ENR0,
  input  logic [ADDR_W-1:0] RDA0,
  input  logic              ENR1,
  input  logic [ADDR_W-1:0] RDA1,
  input  logic              CLR,
  output logic [DATA_W-1:0] Q0,
  output logic [DATA_W-1:0] Q1,
  output logic              BUSY
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam bit              ZR       = (ZERO_REG != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ptr_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                busy;
  logic                wr_en;
  logic                rd0_zero;
  logic                rd1_zero;
  logic [DATA_W-1:0]   q0_d;
  logic [DATA_W-1:0]   q1_d;

  // BUSY decodes directly from the state flop, so it is glitch-free.
  assign busy = (state_q == SWEEP);
  assign BUSY = busy;

  // A CLR edge in IDLE discards the same-edge write; register 0 is read-only when hardwired.
  assign wr_en    = ENW && !busy && !CLR && !(ZR && (WRA == '0));
  assign rd0_zero = ZR && (RDA0 == '0);
  assign rd1_zero = ZR && (RDA1 == '0);

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (busy) begin
      mem[ptr_q] <= '0;
    end else if (wr_en) begin
      mem[WRA] <= D;
    end
  end

  // Read data: new write data wins over stored contents when addresses match.
  always_comb begin
    q0_d = '0;
    q1_d = '0;
    if (!busy && ENR0 && !rd0_zero) begin
      q0_d = (wr_en && (RDA0 == WRA)) ? D : mem[RDA0];
    end
    if (!busy && ENR1 && !rd1_zero) begin
      q1_d = (wr_en && (RDA1 == WRA)) ? D : mem[RDA1];
    end
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      Q0 <= '0;
      Q1 <= '0;
    end else begin
      Q0 <= q0_d;
      Q1 <= q1_d;
    end
  end

endmodule
